// File: rtl/tick_stage_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tss_pkg                                                   |
// | Purpose  : Shared types and helpers for the tick stage sequencer:    |
// |            state encoding, default geometry, and the stage-length    |
// |            field extractor.                                          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package tss_pkg;

  localparam int TSS_NSTAGES_DEF = 4;
  localparam int TSS_TW_DEF      = 4;
  localparam int TSS_SW_DEF      = 2;

  // Upper bounds the extractor is sized for (16 stages of up to 16 bits).
  localparam int TSS_MAX_NSTAGES = 16;
  localparam int TSS_MAX_TW      = 16;
  localparam int TSS_MAX_FLAT    = TSS_MAX_NSTAGES * TSS_MAX_TW;

  typedef enum logic [1:0] {
    TSS_IDLE = 2'd0,
    TSS_RUN  = 2'd1,
    TSS_HOLD = 2'd2,
    TSS_DONE = 2'd3
  } tss_state_e;

  // Returns field idx of a flattened table of tw-bit fields. The caller
  // zero-extends its table to TSS_MAX_FLAT and truncates the result to tw.
  function automatic logic [TSS_MAX_TW-1:0] tss_field(
    input logic [TSS_MAX_FLAT-1:0] flat,
    input int unsigned             idx,
    input int unsigned             tw
  );
    return TSS_MAX_TW'(flat >> (idx * tw));
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_stage_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tick_stage_sequencer_if                                   |
// | Purpose  : Control/status bundle between a controller (master) and   |
// |            the tick stage sequencer (slave).                         |
// | Signals  : tick, start, loop_en, stage_len[NSTAGES*TW] -> sequencer  |
// |            stage[SW], stage_start, running, holding, done <- seq.    |
// |            skip -> sequencer, only when TSS_SKIP_EN is defined.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface tick_stage_sequencer_if
  import tss_pkg::*;
#(
  parameter int NSTAGES = TSS_NSTAGES_DEF,
  parameter int TW      = TSS_TW_DEF,
  parameter int SW      = TSS_SW_DEF
) ();

  logic                    tick;
  logic                    start;
  logic                    loop_en;
  logic [NSTAGES*TW-1:0]   stage_len;
`ifdef TSS_SKIP_EN
  logic                    skip;
`endif
  logic [SW-1:0]           stage;
  logic                    stage_start;
  logic                    running;
  logic                    holding;
  logic                    done;

  modport master (
    output tick, start, loop_en, stage_len,
`ifdef TSS_SKIP_EN
    output skip,
`endif
    input  stage, stage_start, running, holding, done
  );

  modport slave (
    input  tick, start, loop_en, stage_len,
`ifdef TSS_SKIP_EN
    input  skip,
`endif
    output stage, stage_start, running, holding, done
  );

endinterface
`default_nettype wire

// File: rtl/tick_stage_sequencer_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tss_tick_timer                                            |
// | Purpose  : Loadable TW-bit down-counter holding the remaining ticks  |
// |            of the current stage.                                     |
// | Ports    : clk, rst_n (async, active-low), rst_val (value taken      |
// |            while in reset), load/load_val, dec, zero (count == 0).   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tss_tick_timer
  import tss_pkg::*;
#(
  parameter int TW = TSS_TW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [TW-1:0] rst_val,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= rst_val;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/tick_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tick_stage_sequencer                                      |
// | Purpose  : Steps through NSTAGES stages, each lasting a programmable |
// |            number of ticks (field L>0 -> L+1 ticks, L=0 -> hold).    |
// |            Loop / one-shot modes, restart via start.                 |
// | Ports    : clk, rst_n (async, active-low),                           |
// |            bus (tick_stage_sequencer_if.slave): tick, start,         |
// |            loop_en, stage_len in; stage, stage_start, running,       |
// |            holding, done out (all registered).                       |
// | Options  : TSS_SKIP_EN adds bus.skip, forcing an advance in RUN/HOLD.|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tick_stage_sequencer
  import tss_pkg::*;
#(
  parameter int NSTAGES   = TSS_NSTAGES_DEF,
  parameter int TW        = TSS_TW_DEF,
  parameter int SW        = TSS_SW_DEF,
  parameter int AUTOSTART = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tick_stage_sequencer_if.slave bus
);

  localparam logic [SW-1:0] c_last_stage = SW'(NSTAGES - 1);

  tss_state_e          r_state;
  tss_state_e          w_state_nx;
  tss_state_e          w_rst_state;
  logic [SW-1:0]       r_stage;
  logic [SW-1:0]       w_stage_nx;
  logic [SW-1:0]       w_next_idx;
  logic                r_stage_start;
  logic                w_stage_start_nx;
  logic                r_running;
  logic                r_holding;
  logic                r_done;
  logic                w_running_nx;
  logic                w_holding_nx;
  logic                w_done_nx;
  logic                w_load;
  logic                w_dec;
  logic                w_timer_zero;
  logic                w_advance;
  logic                w_skip_ok;
  logic [TW-1:0]       w_field0;
  logic [TW-1:0]       w_field_nx;
  logic [TW-1:0]       w_load_val;
  logic [TSS_MAX_FLAT-1:0] w_flat;

`ifdef TSS_SKIP_EN
  assign w_skip_ok = bus.skip && ((r_state == TSS_RUN) || (r_state == TSS_HOLD));
`else
  assign w_skip_ok = 1'b0;
`endif

  assign w_flat     = TSS_MAX_FLAT'(bus.stage_len);
  // Wrap by compare so non-power-of-two NSTAGES never reaches an unused index.
  assign w_next_idx = (r_stage < c_last_stage) ? (r_stage + 1'b1) : '0;
  assign w_field0   = TW'(tss_field(w_flat, 32'd0, TW));
  assign w_field_nx = TW'(tss_field(w_flat, 32'(w_next_idx), TW));
  assign w_load_val = bus.start ? w_field0 : w_field_nx;
  assign w_advance  = w_skip_ok || ((r_state == TSS_RUN) && bus.tick && w_timer_zero);

  // Reset lands directly in the first stage (or its hold) when autostarting.
  always_comb begin
    w_rst_state = TSS_IDLE;
    if (AUTOSTART != 0) begin
      if (w_field0 == '0) w_rst_state = TSS_HOLD;
      else                w_rst_state = TSS_RUN;
    end
  end

  tss_tick_timer #(
    .TW (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .rst_val  (w_field0),
    .load     (w_load),
    .load_val (w_load_val),
    .dec      (w_dec),
    .zero     (w_timer_zero)
  );

  // State register, stage index and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= w_rst_state;
      r_stage       <= '0;
      r_stage_start <= 1'b0;
      r_running     <= 1'b0;
      r_holding     <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_stage       <= w_stage_nx;
      r_stage_start <= w_stage_start_nx;
      r_running     <= w_running_nx;
      r_holding     <= w_holding_nx;
      r_done        <= w_done_nx;
    end
  end

  // Next state: start beats skip beats tick; a tick that coincides with a
  // start is absorbed by the restart.
  always_comb begin
    w_state_nx       = r_state;
    w_stage_nx       = r_stage;
    w_stage_start_nx = 1'b0;
    w_load           = 1'b0;
    w_dec            = 1'b0;
    if (bus.start) begin
      w_load           = 1'b1;
      w_stage_nx       = '0;
      w_stage_start_nx = 1'b1;
      w_state_nx       = (w_field0 == '0) ? TSS_HOLD : TSS_RUN;
    end else if (w_advance) begin
      if (!(r_stage < c_last_stage) && !bus.loop_en) begin
        // One-shot end: index stays on the last stage, no entry pulse.
        w_state_nx = TSS_DONE;
      end else begin
        w_load           = 1'b1;
        w_stage_nx       = w_next_idx;
        w_stage_start_nx = 1'b1;
        w_state_nx       = (w_field_nx == '0) ? TSS_HOLD : TSS_RUN;
      end
    end else if ((r_state == TSS_RUN) && bus.tick) begin
      w_dec = 1'b1;
    end
  end

  // Status flags follow the next state so they line up with the stage index.
  always_comb begin
    w_running_nx = (w_state_nx == TSS_RUN);
    w_holding_nx = (w_state_nx == TSS_HOLD);
    w_done_nx    = (w_state_nx == TSS_DONE);
  end

  assign bus.stage       = r_stage;
  assign bus.stage_start = r_stage_start;
  assign bus.running     = r_running;
  assign bus.holding     = r_holding;
  assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tick_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tick_stage_sequencer                                   |
// | Purpose  : Self-checking bench for tick_stage_sequencer: a table of  |
// |            per-clock vectors, hand sequences for multi-cycle cases,  |
// |            and randomized stimulus against a tick-counting model.    |
// |            Skip scenarios are included when TSS_SKIP_EN is defined. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_tick_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        loop_en = 1'b0;
  logic        skip = 1'b0;
  logic [15:0] stage_len = 16'h0773;
  logic [5:0]  out_a;
  logic [5:0]  out_b;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  tick_stage_sequencer_if #(.NSTAGES(4), .TW(4), .SW(2)) bus_a ();
  tick_stage_sequencer_if #(.NSTAGES(4), .TW(4), .SW(2)) bus_b ();

  assign bus_a.tick = tick;
  assign bus_a.start = start;
  assign bus_a.loop_en = loop_en;
  assign bus_a.stage_len = stage_len;
  assign bus_b.tick = tick;
  assign bus_b.start = start;
  assign bus_b.loop_en = loop_en;
  assign bus_b.stage_len = stage_len;
`ifdef TSS_SKIP_EN
  assign bus_a.skip = skip;
  assign bus_b.skip = skip;
`endif

  tick_stage_sequencer #(.NSTAGES(4), .TW(4), .SW(2), .AUTOSTART(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  tick_stage_sequencer #(.NSTAGES(4), .TW(4), .SW(2), .AUTOSTART(0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  assign out_a = {bus_a.stage, bus_a.stage_start, bus_a.running, bus_a.holding, bus_a.done};
  assign out_b = {bus_b.stage, bus_b.stage_start, bus_b.running, bus_b.holding, bus_b.done};

  // Packs {stage, stage_start, running, holding, done}.
  function automatic logic [5:0] ev(int st, int ss, int r, int h, int d);
    logic [1:0] s2;
    s2 = st[1:0];
    return {s2, ss[0], r[0], h[0], d[0]};
  endfunction

  task automatic chk(string name, logic [5:0] act, logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual={stage,ss,run,hold,done}=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic do_reset(logic [15:0] sl, logic lp);
    stage_len = sl;
    loop_en = lp;
    tick = 1'b0;
    start = 1'b0;
    skip = 1'b0;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // ---------------- reference model: counts remaining ticks per stage ----
  int         m_stage;
  int         m_mode;   // 0 idle, 1 run, 2 hold, 3 done
  int         m_left;
  int         m_pulse;
  logic [5:0] m_exp;

  function automatic int fld(int s);
    return int'(stage_len[s*4 +: 4]);
  endfunction

  task automatic m_enter(int s);
    m_stage = s;
    m_pulse = 1;
    if (fld(s) == 0) begin
      m_mode = 2;
    end else begin
      m_mode = 1;
      m_left = fld(s) + 1;
    end
  endtask

  task automatic m_advance();
    if (m_stage < 3)  m_enter(m_stage + 1);
    else if (loop_en) m_enter(0);
    else              m_mode = 3;
  endtask

  task automatic m_reset();
    m_stage = 0;
    m_pulse = 0;
    m_mode  = (fld(0) == 0) ? 2 : 1;
    m_left  = fld(0) + 1;
    m_exp   = '0;
  endtask

  task automatic m_edge();
    m_pulse = 0;
    if (start) begin
      m_enter(0);
    end else if (skip && (m_mode == 1 || m_mode == 2)) begin
      m_advance();
    end else if (m_mode == 1 && tick) begin
      m_left--;
      if (m_left == 0) m_advance();
    end
    m_exp = ev(m_stage, m_pulse, int'(m_mode == 1), int'(m_mode == 2), int'(m_mode == 3));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       tk;
    logic       st;
    logic       lp;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(int tk, int st, int lp, logic [5:0] e);
    vec_t v;
    v.tk = tk[0];
    v.st = st[0];
    v.lp = lp[0];
    v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    int pulses;
    logic [15:0] sl;

    // Fields {1,1,1,1}: two ticks per stage; wrap, then one-shot end, restart.
    add(1, 0, 1, ev(0, 0, 1, 0, 0));
    add(1, 0, 1, ev(1, 1, 1, 0, 0));
    add(0, 0, 1, ev(1, 0, 1, 0, 0));
    add(1, 0, 1, ev(1, 0, 1, 0, 0));
    add(1, 0, 1, ev(2, 1, 1, 0, 0));
    add(1, 0, 1, ev(2, 0, 1, 0, 0));
    add(1, 0, 1, ev(3, 1, 1, 0, 0));
    add(1, 0, 1, ev(3, 0, 1, 0, 0));
    add(1, 0, 1, ev(0, 1, 1, 0, 0));
    add(1, 0, 0, ev(0, 0, 1, 0, 0));
    add(1, 0, 0, ev(1, 1, 1, 0, 0));
    add(1, 0, 0, ev(1, 0, 1, 0, 0));
    add(1, 0, 0, ev(2, 1, 1, 0, 0));
    add(1, 0, 0, ev(2, 0, 1, 0, 0));
    add(1, 0, 0, ev(3, 1, 1, 0, 0));
    add(1, 0, 0, ev(3, 0, 1, 0, 0));
    add(1, 0, 0, ev(3, 0, 0, 0, 1));
    add(1, 0, 1, ev(3, 0, 0, 0, 1));
    add(1, 1, 0, ev(0, 1, 1, 0, 0));
    add(1, 0, 0, ev(0, 0, 1, 0, 0));
    add(1, 0, 0, ev(1, 1, 1, 0, 0));

    // ---- reset state ----
    rst_n = 1'b0;
    cyc();
    chk("reset_a", out_a, ev(0, 0, 0, 0, 0));
    chk("reset_b", out_b, ev(0, 0, 0, 0, 0));

    // ---- table ----
    do_reset(16'h1111, 1'b1);
    chk("release_a", out_a, ev(0, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      tick = tbl[i].tk;
      start = tbl[i].st;
      loop_en = tbl[i].lp;
      cyc();
      chk($sformatf("tbl_row%0d", i), out_a, tbl[i].exp);
    end
    tick = 1'b0;
    start = 1'b0;

    // ---- fields {3,7,7,0}, tick every 4 clk ----
    do_reset(16'h0773, 1'b0);
    pulses = 0;
    for (int k = 1; k <= 28; k++) begin
      for (int j = 0; j < 3; j++) begin
        tick = 1'b0;
        cyc();
        pulses += int'(bus_a.stage_start);
      end
      tick = 1'b1;
      cyc();
      pulses += int'(bus_a.stage_start);
      chk($sformatf("slow_tick%0d", k), out_a,
          ev((k < 4) ? 0 : (k < 12) ? 1 : (k < 20) ? 2 : 3,
             int'(k == 4 || k == 12 || k == 20), int'(k < 20), int'(k >= 20), 0));
    end
    tick = 1'b0;
    chk_int("slow_pulse_count", pulses, 3);

    // ---- start with tick mid-stage 2 ----
    do_reset(16'h0773, 1'b0);
    ticks(14);
    chk("pre_start", out_a, ev(2, 0, 1, 0, 0));
    start = 1'b1;
    tick = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_tick", out_a, ev(0, 1, 1, 0, 0));
    for (int i = 1; i <= 3; i++) begin
      ticks(1);
      chk($sformatf("after_start%0d", i), out_a, ev(0, 0, 1, 0, 0));
    end
    ticks(1);
    chk("after_start4", out_a, ev(1, 1, 1, 0, 0));

    // ---- field sampling at entry ----
    do_reset(16'h0773, 1'b0);
    stage_len = 16'h0723;
    ticks(4);
    chk("fs_enter1", out_a, ev(1, 1, 1, 0, 0));
    ticks(2);
    chk("fs_mid1", out_a, ev(1, 0, 1, 0, 0));
    ticks(1);
    chk("fs_enter2", out_a, ev(2, 1, 1, 0, 0));
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("fs_restart", out_a, ev(0, 1, 1, 0, 0));
    ticks(4);
    chk("fs_reenter1", out_a, ev(1, 1, 1, 0, 0));
    stage_len = 16'h0773;
    ticks(2);
    chk("fs_late_mid1", out_a, ev(1, 0, 1, 0, 0));
    ticks(1);
    chk("fs_late_enter2", out_a, ev(2, 1, 1, 0, 0));

    // ---- asynchronous reset mid stage 1; AUTOSTART=0 instance ----
    do_reset(16'h0773, 1'b0);
    ticks(5);
    chk("ar_pre", out_a, ev(1, 0, 1, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async_a", out_a, ev(0, 0, 0, 0, 0));
    chk("ar_async_b", out_b, ev(0, 0, 0, 0, 0));
    cyc();
    rst_n = 1'b1;
    ticks(5);
    chk("ar_restart_a", out_a, ev(1, 0, 1, 0, 0));
    chk("idle_ignores_tick", out_b, ev(0, 0, 0, 0, 0));
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("idle_start_b", out_b, ev(0, 1, 1, 0, 0));

`ifdef TSS_SKIP_EN
    // ---- skip ----
    do_reset(16'h0773, 1'b1);
    skip = 1'b1;
    cyc();
    chk("skip1", out_a, ev(1, 1, 1, 0, 0));
    cyc();
    chk("skip2", out_a, ev(2, 1, 1, 0, 0));
    cyc();
    chk("skip3_hold", out_a, ev(3, 1, 0, 1, 0));
    skip = 1'b0;
    ticks(2);
    chk("hold_ignores_tick", out_a, ev(3, 0, 0, 1, 0));
    skip = 1'b1;
    cyc();
    chk("skip_hold_wrap", out_a, ev(0, 1, 1, 0, 0));
    cyc();
    chk("skip_again", out_a, ev(1, 1, 1, 0, 0));
    start = 1'b1;
    cyc();
    start = 1'b0;
    skip = 1'b0;
    chk("skip_start", out_a, ev(0, 1, 1, 0, 0));
    ticks(3);
    chk("skip_start_len", out_a, ev(0, 0, 1, 0, 0));
    ticks(1);
    chk("skip_start_adv", out_a, ev(1, 1, 1, 0, 0));
`endif

    // ---- randomized against the model ----
    for (int blk = 0; blk < 12; blk++) begin
      sl = '0;
      for (int f = 0; f < 4; f++)
        sl[f*4 +: 4] = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
      do_reset(sl, 1'($urandom_range(0, 1)));
      m_reset();
      chk("rand_reset", out_a, m_exp);
      for (int c = 0; c < 150; c++) begin
        tick = ($urandom_range(0, 2) != 0);
        start = ($urandom_range(0, 39) == 0);
        loop_en = 1'($urandom_range(0, 1));
`ifdef TSS_SKIP_EN
        skip = ($urandom_range(0, 14) == 0);
`endif
        if (c % 50 == 49) begin
          for (int f = 0; f < 4; f++)
            stage_len[f*4 +: 4] = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
        end
        cyc();
        m_edge();
        chk($sformatf("rand_b%0d_c%0d", blk, c), out_a, m_exp);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
